// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and the RAM: one request at a time,
// misaligned halfword/word accesses become byte beats, loads are extended on return.
module load_store_unit #(
    parameter int unsigned ADDRESS_LIMIT    = 16384,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [3:0]  ram_control,
    output logic [31:0] ram_address,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state, next_state;

    logic        lat_write;
    logic        lat_unsigned;
    logic        lat_split;
    logic        lat_error;
    logic [1:0]  lat_size;
    logic [1:0]  beat;
    logic [1:0]  last_beat;
    logic [31:0] lat_address;
    logic [31:0] lat_write_data;
    logic [31:0] raw_data;
    logic [31:0] ext_data;

    logic [32:0] req_bytes;
    logic [32:0] req_end;
    logic        req_misaligned;
    logic        req_error;
    logic        accept;

    // The end address is formed in 33 bits so a request near 2^32 cannot wrap into range.
    always_comb begin
        req_bytes = 33'd1;
        case (req_size)
            2'b01:   req_bytes = 33'd2;
            2'b10:   req_bytes = 33'd4;
            default: req_bytes = 33'd1;
        endcase
        req_end        = {1'b0, req_address} + req_bytes - 33'd1;
        req_misaligned = ((req_size == 2'b01) && req_address[0]) ||
                         ((req_size == 2'b10) && (req_address[1:0] != 2'b00));
        req_error      = (req_size == 2'b11) ||
                         (req_end >= 33'(ADDRESS_LIMIT)) ||
                         (req_misaligned && !SPLIT_MISALIGNED);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        accept         = 1'b0;
        ram_control    = 4'b0000;
        ram_address    = 32'h0;
        ram_write_data = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_error ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
                if (lat_split) begin
                    ram_control    = {1'b1, 1'b0, 1'b1, lat_write};
                    ram_address    = lat_address + {30'h0, beat};
                    ram_write_data = {24'h0, lat_write_data[{beat, 3'b000} +: 8]};
                end else begin
                    ram_control    = {(lat_size != 2'b10), (lat_size == 2'b01),
                                      (lat_size == 2'b00), lat_write};
                    ram_address    = lat_address;
                    ram_write_data = lat_write_data;
                end
                if (beat == last_beat) begin
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // A beat in flight when reset arrives must not commit at that edge.
        if (!reset) begin
            ram_control = 4'b0000;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_write      <= 1'b0;
            lat_unsigned   <= 1'b0;
            lat_split      <= 1'b0;
            lat_error      <= 1'b0;
            lat_size       <= 2'b00;
            lat_address    <= 32'h0;
            lat_write_data <= 32'h0;
            beat           <= 2'd0;
            last_beat      <= 2'd0;
            raw_data       <= 32'h0;
        end else if (accept) begin
            lat_write      <= req_write;
            lat_unsigned   <= req_unsigned;
            lat_split      <= req_misaligned;
            lat_error      <= req_error;
            lat_size       <= req_size;
            lat_address    <= req_address;
            lat_write_data <= req_write_data;
            beat           <= 2'd0;
            last_beat      <= !req_misaligned ? 2'd0 : ((req_size == 2'b01) ? 2'd1 : 2'd3);
            raw_data       <= 32'h0;
        end else if (state == ACCESS) begin
            if (lat_split) begin
                raw_data[{beat, 3'b000} +: 8] <= ram_read_data[7:0];
            end else begin
                raw_data <= ram_read_data;
            end
            beat <= beat + 2'd1;
        end
    end

    always_comb begin
        case (lat_size)
            2'b00:   ext_data = {{24{!lat_unsigned && raw_data[7]}}, raw_data[7:0]};
            2'b01:   ext_data = {{16{!lat_unsigned && raw_data[15]}}, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
        resp_data  = 32'h0;
        resp_error = 1'b0;
        if (state == RESPOND) begin
            resp_error = lat_error;
            if (!lat_error && !lat_write) begin
                resp_data = ext_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array RAM, byte-level reference
// memory model, directed literal cases, randomized traffic and a mid-access reset.
module tb_load_store_unit;

    localparam int LIMIT = 16384;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_write_data;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_data;
    logic [3:0]  ram_control;
    logic [31:0] ram_address, ram_write_data, ram_read_data;

    logic        ns_req_valid, ns_req_ready, ns_req_write, ns_req_unsigned;
    logic [1:0]  ns_req_size;
    logic [31:0] ns_req_address, ns_req_write_data;
    logic        ns_resp_valid, ns_resp_ready, ns_resp_error;
    logic [31:0] ns_resp_data;
    logic [3:0]  ns_ram_control;
    logic [31:0] ns_ram_address, ns_ram_write_data, ns_ram_read_data;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [LIMIT];
    logic [7:0]  ref_mem [LIMIT];
    logic [13:0] ra;

    logic        exp_pending = 1'b0;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        monitor_on = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_data;
    logic        prev_err;
    int          write_beats = 0;

    always #5 clock = ~clock;

    load_store_unit #(.ADDRESS_LIMIT(LIMIT), .SPLIT_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_error(resp_error),
        .ram_control(ram_control), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    load_store_unit #(.ADDRESS_LIMIT(LIMIT), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clock(clock), .reset(reset),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_write(ns_req_write),
        .req_size(ns_req_size), .req_unsigned(ns_req_unsigned), .req_address(ns_req_address),
        .req_write_data(ns_req_write_data),
        .resp_valid(ns_resp_valid), .resp_ready(ns_resp_ready), .resp_data(ns_resp_data),
        .resp_error(ns_resp_error),
        .ram_control(ns_ram_control), .ram_address(ns_ram_address),
        .ram_write_data(ns_ram_write_data), .ram_read_data(ns_ram_read_data)
    );

    assign ra = ram_address[13:0];
    assign ns_ram_read_data = 32'h0000_00A5;

    // RAM read is combinational and zero-pads byte/half reads.
    always_comb begin
        case (ram_control[2:1])
            2'b01:   ram_read_data = {24'h0, mem[ra]};
            2'b10:   ram_read_data = {16'h0, mem[ra + 14'd1], mem[ra]};
            default: ram_read_data = {mem[ra + 14'd3], mem[ra + 14'd2], mem[ra + 14'd1], mem[ra]};
        endcase
    end

    initial begin
        for (int i = 0; i < LIMIT; i++) mem[i] = 8'((i * 73 + 29) & 255);
        forever begin
            @(posedge clock);
            if (ram_control[0]) begin
                if (ram_address >= 32'(LIMIT)) begin
                    failures++;
                    $display("[TB] FAIL ram_write_range actual=0x%08h limit=0x%08h", ram_address, LIMIT);
                end
                case (ram_control[2:1])
                    2'b01: mem[ra] <= ram_write_data[7:0];
                    2'b10: begin
                        mem[ra]         <= ram_write_data[7:0];
                        mem[ra + 14'd1] <= ram_write_data[15:8];
                    end
                    default: begin
                        mem[ra]         <= ram_write_data[7:0];
                        mem[ra + 14'd1] <= ram_write_data[15:8];
                        mem[ra + 14'd2] <= ram_write_data[23:16];
                        mem[ra + 14'd3] <= ram_write_data[31:24];
                    end
                endcase
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Reference: a request is a list of bytes at addr..addr+n-1; beats = n when misaligned, else 1.
    task automatic model_request(input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 output int lat, output int writes);
        int nb;
        logic [32:0] last;
        logic mis, err;
        logic [31:0] v;
        nb   = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        last = {1'b0, addr} + 33'(nb) - 33'd1;
        mis  = (addr & 32'(nb - 1)) != 32'h0;
        err  = (sz == 2'b11) || (last >= 33'(LIMIT));
        exp_err  = err;
        exp_data = 32'h0;
        if (err) begin
            lat = 1;
            writes = 0;
        end else begin
            lat = (mis ? nb : 1) + 1;
            if (w) begin
                writes = mis ? nb : 1;
                for (int i = 0; i < nb; i++) ref_mem[14'(addr + 32'(i))] = data[8*i +: 8];
            end else begin
                writes = 0;
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[14'(addr + 32'(i))]) << (8 * i));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                exp_data = v;
            end
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] data, input int hold,
                                  output logic [31:0] got_data, output logic got_err, output int got_lat);
        int exp_lat, exp_writes, lat;
        @(negedge clock);
        check_output("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_address = addr; req_write_data = data;
        model_request(w, sz, uns, addr, data, exp_lat, exp_writes);
        exp_pending = 1'b1;
        write_beats = 0;
        @(negedge clock);
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1); req_address = $urandom; req_write_data = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check_output("latency", 32'(lat), 32'(exp_lat));
        got_data = resp_data;
        got_err  = resp_error;
        got_lat  = lat;
        repeat (hold) @(negedge clock);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check_output("resp_dropped", 32'(resp_valid), 32'd0);
        check_output("req_ready_back", 32'(req_ready), 32'd1);
        check_output("write_beats", 32'(write_beats), 32'(exp_writes));
        exp_pending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (addr + 32'(i) < 32'(LIMIT) && addr < 32'(LIMIT))
                check_output("mem_bytes", 32'(mem[14'(addr + 32'(i))]), 32'(ref_mem[14'(addr + 32'(i))]));
        end
    endtask

    // Every cycle: response must match the model and stay stable until taken; RAM idle outside accesses.
    always @(posedge clock) begin
        #1;
        if (monitor_on) begin
            if (ram_control[0]) write_beats++;
            if (!exp_pending) check_output("resp_unexpected", 32'(resp_valid), 32'd0);
            if (resp_valid) begin
                if (exp_pending) begin
                    check_output("resp_data", resp_data, exp_data);
                    check_output("resp_error", 32'(resp_error), 32'(exp_err));
                end
                check_output("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (prev_valid) begin
                    check_output("resp_data_stable", resp_data, prev_data);
                    check_output("resp_error_stable", 32'(resp_error), 32'(prev_err));
                end
            end else begin
                check_output("resp_data_idle", resp_data, 32'h0);
                check_output("resp_error_idle", 32'(resp_error), 32'd0);
            end
            if (req_ready || resp_valid) check_output("ram_control_idle", 32'(ram_control), 32'd0);
            prev_valid = resp_valid;
            prev_data  = resp_data;
            prev_err   = resp_error;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [7:0]  old3, old4;
        int          bad;

        for (int i = 0; i < LIMIT; i++) ref_mem[i] = 8'((i * 73 + 29) & 255);
        reset = 1'b0; resp_ready = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_address = 32'h0; req_write_data = 32'h0;
        ns_req_valid = 1'b0; ns_req_write = 1'b0; ns_req_size = 2'b00; ns_req_unsigned = 1'b0;
        ns_req_address = 32'h0; ns_req_write_data = 32'h0; ns_resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        check_output("rst_req_ready", 32'(req_ready), 32'd1);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_data", resp_data, 32'h0);
        check_output("rst_resp_error", 32'(resp_error), 32'd0);
        check_output("rst_ram_control", 32'(ram_control), 32'd0);
        check_output("rst_ram_address", ram_address, 32'h0);
        check_output("rst_ram_write_data", ram_write_data, 32'h0);
        reset = 1'b1;
        monitor_on = 1'b1;

        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, d, e, l);
        check_output("lit_store_err", 32'(e), 32'd0);
        check_output("lit_store_data", d, 32'h0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, d, e, l);
        check_output("lit_load_word", d, 32'hDEADBEEF);
        check_output("lit_load_word_lat", 32'(l), 32'd2);
        apply_stimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, d, e, l);
        check_output("lit_load_byte_s", d, 32'hFFFFFFBE);
        apply_stimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 2, d, e, l);
        check_output("lit_load_byte_u", d, 32'h000000BE);
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h203, 32'h11223344, 5, d, e, l);
        check_output("lit_split_store_lat", 32'(l), 32'd5);
        check_output("lit_byte_203", 32'(mem[14'h203]), 32'h44);
        check_output("lit_byte_206", 32'(mem[14'h206]), 32'h11);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h203, 32'h0, 0, d, e, l);
        check_output("lit_split_load", d, 32'h11223344);
        check_output("lit_split_load_lat", 32'(l), 32'd5);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, d, e, l);
        check_output("lit_load_200_top", 32'(d[31:24]), 32'h44);
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h205, 32'h0, 0, d, e, l);
        check_output("lit_split_half", d, 32'h00001122);
        check_output("lit_split_half_lat", 32'(l), 32'd3);
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h3FFF, 32'h0, 0, d, e, l);
        check_output("lit_range_err", 32'(e), 32'd1);
        check_output("lit_range_lat", 32'(l), 32'd1);
        apply_stimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 0, d, e, l);
        check_output("lit_size_err", 32'(e), 32'd1);
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFEF00D, 0, d, e, l);
        check_output("lit_top_word_ok", 32'(e), 32'd0);
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h3FFD, 32'h01020304, 0, d, e, l);
        check_output("lit_top_word_err", 32'(e), 32'd1);
        apply_stimulus(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 0, d, e, l);
        check_output("lit_wrap_err", 32'(e), 32'd1);

        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'(LIMIT - 4) + 32'($urandom_range(0, 7));
                default: addr = 32'($urandom_range(0, LIMIT - 1));
            endcase
            apply_stimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
                           $urandom_range(0, 3), d, e, l);
        end

        // Reset lands during beat 2 of a split word store at 0x301.
        old3 = ref_mem[14'h303];
        old4 = ref_mem[14'h304];
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_address = 32'h301; req_write_data = 32'hAABBCCDD;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_output("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check_output("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("mid_rst_ram_control", 32'(ram_control), 32'd0);
        check_output("mid_rst_byte0", 32'(mem[14'h301]), 32'hDD);
        check_output("mid_rst_byte1", 32'(mem[14'h302]), 32'hCC);
        check_output("mid_rst_byte2", 32'(mem[14'h303]), 32'(old3));
        check_output("mid_rst_byte3", 32'(mem[14'h304]), 32'(old4));
        ref_mem[14'h301] = 8'hDD;
        ref_mem[14'h302] = 8'hCC;
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 0, d, e, l);
        check_output("post_rst_load", d, {old4, old3, 8'hCC, 8'hDD});

        // Instance with splitting disabled: misaligned is an error, aligned byte still loads.
        @(negedge clock);
        ns_req_valid = 1'b1; ns_req_size = 2'b01; ns_req_address = 32'h101;
        @(negedge clock);
        ns_req_valid = 1'b0;
        check_output("ns_mis_valid", 32'(ns_resp_valid), 32'd1);
        check_output("ns_mis_err", 32'(ns_resp_error), 32'd1);
        @(negedge clock);
        check_output("ns_mis_done", 32'(ns_req_ready), 32'd1);
        ns_req_valid = 1'b1; ns_req_size = 2'b00; ns_req_address = 32'h101;
        @(negedge clock);
        ns_req_valid = 1'b0;
        check_output("ns_byte_access", 32'(ns_resp_valid), 32'd0);
        @(negedge clock);
        check_output("ns_byte_valid", 32'(ns_resp_valid), 32'd1);
        check_output("ns_byte_err", 32'(ns_resp_error), 32'd0);
        check_output("ns_byte_data", ns_resp_data, 32'hFFFFFFA5);

        @(negedge clock);
        monitor_on = 1'b0;
        bad = 0;
        for (int i = 0; i < LIMIT; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_output("mem_final", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
